uart_transmit: RTL and testbench

UART_TRANSMIT -- requirements
Module: uart_transmit

---
 rtl/uart_transmit_pkg.sv | 23 ++
 rtl/uart_tx_bps.sv | 38 +++
 rtl/uart_transmit.sv | 167 ++++++++++++++++
 tb/tb_uart_transmit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_transmit_pkg.sv
// Shared UART definitions: FSM state encoding, default CLK_FREQ/BAUD and the BPS_CNT
// derivation; ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_transmit_pkg;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 9600;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } tx_state_e;

    function automatic int calc_bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_bps.sv
// Bit-period tick generator: counts 0..BPS_CNT-1 while cnt_start is high, held at 0 otherwise.
// bps_sig is combinational from the counter and marks the last clock of every bit period.
module uart_tx_bps
    import uart_transmit_pkg::*;
#(
    parameter int BPS_CNT = calc_bps_cnt(DEF_CLK_FREQ, DEF_BAUD)
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_start,
    output logic bps_sig
);

    localparam int               CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrapping at CNT_LAST restarts the count for a back-to-back frame without a gap.
    always_comb begin
        cnt_d = '0;
        if (cnt_start && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bps_sig = cnt_start && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter with a one-deep holding register; line goes low 2 clocks after accept.
// tx_en is dropped while tx_rdy=0; UART_TX_PARITY_EN adds an even-parity bit (11-bit frame).
module uart_transmit
    import uart_transmit_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx_rdy,
    output logic       tx_busy,
    output logic       tx_int,
    output logic       uart_txd
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, BAUD);

    tx_state_e  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       txd_q, txd_d;
    logic       bps_sig;
    logic       load;
`ifdef UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    uart_tx_bps #(
        .BPS_CNT (BPS_CNT)
    ) u_bps (
        .clk       (clk),
        .rst       (rst),
        .cnt_start (tx_busy),
        .bps_sig   (bps_sig)
    );

    assign tx_rdy   = ~hold_vld_q;
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_int   = (state_q == ST_STOP) && bps_sig;
    assign uart_txd = txd_q;

    // txd_d is the level for the next clock, so every bit change is set up on the last clock of the previous bit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (hold_vld_q) begin
                    load    = 1'b1;
                    state_d = ST_START;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (bps_sig) begin
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bps_sig) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bps_sig) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bps_sig) begin
                    if (hold_vld_q) begin
                        load    = 1'b1;
                        state_d = ST_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
        if (load) begin
            shift_d   = hold_q;
            bit_cnt_d = '0;
        end
    end

    // A load only happens while the holder is full (tx_rdy=0), so it never collides with an accept.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (load) begin
            hold_vld_d = 1'b0;
        end
        if (tx_en && tx_rdy) begin
            hold_vld_d = 1'b1;
            hold_d     = tx_data;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        parity_d = parity_q;
        if (load) begin
            parity_d = ^hold_q;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            txd_q      <= txd_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: frame table, directed corner sequences and random traffic,
// all cross-checked every cycle against a timeline model of frames and the holding register.
module tb_uart_transmit;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int B        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FBITS    = 11;
`else
    localparam int FBITS    = 10;
`endif
    localparam int FB       = FBITS * B;

    typedef struct {
        logic [7:0]  dat;
        logic [10:0] frame;
    } vec_t;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       tx_en   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_rdy;
    logic       tx_busy;
    logic       tx_int;
    logic       uart_txd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: one held byte plus the frame currently occupying the line.
    logic       m_held      = 1'b0;
    logic [7:0] m_held_dat  = 8'h00;
    logic       m_cur_vld   = 1'b0;
    int         m_cur_start = 0;
    logic [7:0] m_cur_dat   = 8'h00;
    int         m_next_free = 0;

    vec_t vecs [6];

    always #5 clk = ~clk;

    uart_transmit #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_rdy   (tx_rdy),
        .tx_busy  (tx_busy),
        .tx_int   (tx_int),
        .uart_txd (uart_txd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if ((k == 9) && (FBITS == 11)) return ^d;
        return 1'b1;
    endfunction

    // Evaluates one clock cycle of the model against the DUT outputs, then applies this cycle's inputs.
    task automatic model_step();
        logic e_txd, e_rdy, e_busy, e_int;
        int   k;
        if (rst) begin
            m_held      = 1'b0;
            m_cur_vld   = 1'b0;
            m_next_free = 0;
            cyc++;
            return;
        end
        e_rdy  = !m_held;
        e_txd  = 1'b1;
        e_busy = 1'b0;
        e_int  = 1'b0;
        if (m_cur_vld && (cyc >= m_cur_start) && (cyc < m_cur_start + FB)) begin
            k      = (cyc - m_cur_start) / B;
            e_txd  = frame_bit(m_cur_dat, k);
            e_busy = 1'b1;
            e_int  = (cyc == m_cur_start + FB - 1);
        end
        check("model_txd",  {31'd0, uart_txd}, {31'd0, e_txd});
        check("model_rdy",  {31'd0, tx_rdy},   {31'd0, e_rdy});
        check("model_busy", {31'd0, tx_busy},  {31'd0, e_busy});
        check("model_int",  {31'd0, tx_int},   {31'd0, e_int});
        if (m_held && (cyc >= m_next_free)) begin
            m_cur_vld   = 1'b1;
            m_cur_start = cyc + 1;
            m_cur_dat   = m_held_dat;
            m_next_free = cyc + FB;
            m_held      = 1'b0;
        end
        if (tx_en && e_rdy) begin
            m_held     = 1'b1;
            m_held_dat = tx_data;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] d, output int at);
        tx_data = d;
        tx_en   = 1'b1;
        at      = cyc;
        tick();
        tx_en   = 1'b0;
    endtask

    task automatic advance_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, expected event did not occur (cycle %0d)", name, cyc);
    endtask

    task automatic wait_low(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (uart_txd === 1'b0) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) bound_fail("wait_low");
    endtask

    task automatic wait_int(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (tx_int === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) bound_fail("wait_int");
    endtask

    task automatic wait_idle(input int limit);
        int ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if ((tx_busy === 1'b0) && (tx_rdy === 1'b1)) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (ok == 0) bound_fail("wait_idle");
    endtask

    task automatic count_ints(input int n, output int pulses, output int lows);
        pulses = 0;
        lows   = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx_int === 1'b1) pulses++;
            if (uart_txd === 1'b0) lows++;
        end
    endtask

    initial begin
        int          ta, tl, ti, n_int, n_low;
        logic [10:0] cap;

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{dat: 8'h55, frame: 11'h4AA};
        vecs[1] = '{dat: 8'h07, frame: 11'h60E};
        vecs[2] = '{dat: 8'hA3, frame: 11'h546};
        vecs[3] = '{dat: 8'h0F, frame: 11'h41E};
        vecs[4] = '{dat: 8'h00, frame: 11'h400};
        vecs[5] = '{dat: 8'hFF, frame: 11'h5FE};
`else
        vecs[0] = '{dat: 8'h55, frame: 11'h2AA};
        vecs[1] = '{dat: 8'h07, frame: 11'h20E};
        vecs[2] = '{dat: 8'hA3, frame: 11'h346};
        vecs[3] = '{dat: 8'h0F, frame: 11'h21E};
        vecs[4] = '{dat: 8'h00, frame: 11'h200};
        vecs[5] = '{dat: 8'hFF, frame: 11'h3FE};
`endif

        repeat (3) tick();
        check("reset_txd",  {31'd0, uart_txd}, 32'd1);
        check("reset_rdy",  {31'd0, tx_rdy},   32'd1);
        check("reset_busy", {31'd0, tx_busy},  32'd0);
        check("reset_int",  {31'd0, tx_int},   32'd0);
        rst = 1'b0;
        tick();
        tick();

        // Single frames from the table: start latency, bit levels at mid-bit, frame length.
        for (int v = 0; v < 6; v++) begin
            wait_idle(3 * FB);
            send_byte(vecs[v].dat, ta);
            wait_low(8, tl);
            check("accept_to_start", tl - ta, 32'd2);
            cap = '0;
            for (int i = 0; i < FBITS; i++) begin
                advance_to(tl + i * B + B / 2);
                cap[i] = uart_txd;
            end
            check("frame_bits", {21'd0, cap}, {21'd0, vecs[v].frame});
            wait_int(FB, ti);
            check("frame_len", ti - tl + 1, FB);
            tick();
            check("idle_after_stop", {31'd0, uart_txd}, 32'd1);
        end

        // Back-to-back: 0xA3 then 0x0F queued while busy.
        wait_idle(3 * FB);
        send_byte(8'hA3, ta);
        wait_low(8, tl);
        advance_to(tl + 3 * B);
        send_byte(8'h0F, ta);
        check("rdy_after_queue", {31'd0, tx_rdy}, 32'd0);
        wait_int(FB, ti);
        check("rdy_at_move", {31'd0, tx_rdy}, 32'd0);
        tick();
        check("no_idle_gap", {31'd0, uart_txd}, 32'd0);
        check("second_start_cycle", cyc, tl + FB);
        check("rdy_after_move", {31'd0, tx_rdy}, 32'd1);
        count_ints(FB + 10, n_int, n_low);
        check("b2b_int_count", n_int + 1, 32'd2);

        // Third byte offered while one frame is active and one is held is dropped.
        wait_idle(3 * FB);
        send_byte(8'h11, ta);
        wait_low(8, tl);
        tick();
        send_byte(8'h22, ta);
        tick();
        send_byte(8'h33, ta);
        count_ints(3 * FB, n_int, n_low);
        check("drop_int_count", n_int, 32'd2);

        // Reset during data bit 4 of 0xFF with a byte queued.
        wait_idle(3 * FB);
        send_byte(8'hFF, ta);
        wait_low(8, tl);
        tick();
        send_byte(8'h5A, ta);
        advance_to(tl + 5 * B + B / 2);
        check("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_txd",  {31'd0, uart_txd}, 32'd1);
        check("rst_busy", {31'd0, tx_busy},  32'd0);
        check("rst_rdy",  {31'd0, tx_rdy},   32'd1);
        check("rst_int",  {31'd0, tx_int},   32'd0);
        tick();
        tick();
        rst = 1'b0;
        count_ints(3 * FB, n_int, n_low);
        check("post_rst_int_count", n_int, 32'd0);
        check("post_rst_line_low",  n_low, 32'd0);

        // tx_en held for three clocks while idle: the move cycle drops the 2nd, the 3rd is queued.
        tx_data = 8'h31;
        tx_en   = 1'b1;
        tick();
        tx_data = 8'h32;
        tick();
        tx_data = 8'h33;
        tick();
        tx_en   = 1'b0;
        count_ints(3 * FB, n_int, n_low);
        check("hold3_int_count", n_int, 32'd2);

        // Random traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            tx_en   = ($urandom_range(0, 49) == 0);
            tx_data = 8'($urandom);
            tick();
        end
        tx_en = 1'b0;
        wait_idle(3 * FB);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
